// File: rtl/cpu_core_param.sv
// -----------------------------------------------------------------------------
// cpu_core_param
//   Parametrised multi-cycle CPU core. Four DATA_W-wide general registers,
//   ADDR_W-wide PC and SP, and a single req/ack bus shared by program memory,
//   data memory and I/O. Every bus access takes one cycle to raise mem_req
//   and completes on the clock edge where mem_req & mem_ack are both high.
//
//   Optional feature: define CPU_CALL_EN to turn op 0 with rd=1 into CALL a
//   and op 0 with rd=2 into RET. Without it every op 0 encoding is a NOP.
//
// Ports
//   clk        core clock
//   reset      synchronous, active-high reset
//   mem_req    access request, held until acked
//   mem_we     1 = write, 0 = read
//   mem_io     1 = I/O space, 0 = memory
//   mem_addr   access address
//   mem_wdata  write data
//   mem_rdata  read data, valid when mem_ack = 1
//   mem_ack    completes the pending access on this clk edge
//   halted     core stopped by HLT
//   flags      {carry, zero}
// -----------------------------------------------------------------------------
module cpu_core_param #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_io,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [1:0]        flags
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_JCC  = 4'hB;
  localparam logic [3:0] OP_PUSH = 4'hC;
  localparam logic [3:0] OP_POP  = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1'b1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_OPND   = 4'd2,
    S_MEM    = 4'd3,
    S_PUSH   = 4'd4,
    S_POP    = 4'd5,
    S_IOW    = 4'd6,
    S_HALT   = 4'd7,
    S_CALLW  = 4'd8,   // CALL: push return address (CPU_CALL_EN only)
    S_RETR   = 4'd9    // RET: pop return address (CPU_CALL_EN only)
  } state_t;

  // ALU result with the carry/borrow in the extra top bit.
  function automatic logic [DATA_W:0] alu_f(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    case (op)
      OP_ADD:         r = {1'b0, a} + {1'b0, b};
      // Top bit of the widened difference is the unsigned borrow (a < b).
      OP_SUB, OP_CMP: r = {1'b0, a} - {1'b0, b};
      OP_AND:         r = {1'b0, a & b};
      OP_OR:          r = {1'b0, a | b};
      OP_XOR:         r = {1'b0, a ^ b};
      default:        r = {(DATA_W+1){1'b0}};
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [7:0]        ir_q, ir_d;
  logic [ADDR_W-1:0] t_q, t_d;       // operand address latched in OPND
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic              c_q, c_d, z_q, z_d;
  logic              req_q, req_d, we_q, we_d, io_q, io_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              halted_q, halted_d;

  logic [3:0]        op_s;
  logic [1:0]        rd_s, rs_s;
  logic [DATA_W:0]   alu_s;
  logic              take_s;
  logic [ADDR_W-1:0] rdata_addr_s;
  logic [ADDR_W-1:0] port_addr_s;

  assign op_s         = ir_q[7:4];
  assign rd_s         = ir_q[3:2];
  assign rs_s         = ir_q[1:0];
  assign alu_s        = alu_f(op_s, rf_q[rd_s], rf_q[rs_s]);
  assign rdata_addr_s = ADDR_W'(mem_rdata);
  assign port_addr_s  = ADDR_W'(rd_s);

  // Branch condition, evaluated on the flags held before the jump.
  always_comb begin
    case (rs_s)
      2'd0:    take_s = 1'b1;
      2'd1:    take_s = z_q;
      2'd2:    take_s = ~z_q;
      2'd3:    take_s = c_q;
      default: take_s = 1'b0;
    endcase
  end

  // Next-state logic: sequencing, bus requests and register write-back.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ir_d    = ir_q;
    t_d     = t_q;
    rf_d    = rf_q;
    c_d     = c_q;
    z_d     = z_q;
    req_d   = req_q;
    we_d    = we_q;
    io_d    = io_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    // Each access state first raises the request (address/data frozen in the
    // bus registers), then waits for the ack edge, which also drops mem_req.
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b0; io_d = 1'b0; addr_d = pc_q;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          ir_d    = mem_rdata[7:0];
          pc_d    = pc_q + ONE_A;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        case (op_s)
          OP_NOP: begin
`ifdef CPU_CALL_EN
            if (rd_s == 2'd1)      state_d = S_OPND;
            else if (rd_s == 2'd2) state_d = S_RETR;
            else                   state_d = S_FETCH;
`else
            state_d = S_FETCH;
`endif
          end
          OP_LDI, OP_LD, OP_ST, OP_JCC: state_d = S_OPND;
          OP_MOV: begin
            rf_d[rd_s] = rf_q[rs_s];
            state_d    = S_FETCH;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
            c_d = alu_s[DATA_W];
            z_d = (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
            if (op_s != OP_CMP) rf_d[rd_s] = alu_s[DATA_W-1:0];
            else                rf_d[rd_s] = rf_q[rd_s];
            state_d = S_FETCH;
          end
          OP_PUSH: state_d = S_PUSH;
          OP_POP:  state_d = S_POP;
          OP_OUT:  state_d = S_IOW;
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end

      S_OPND: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b0; io_d = 1'b0; addr_d = pc_q;
        end else if (mem_ack) begin
          req_d = 1'b0;
          pc_d  = pc_q + ONE_A;
          t_d   = rdata_addr_s;
          case (op_s)
            OP_LDI: begin
              rf_d[rd_s] = mem_rdata;
              state_d    = S_FETCH;
            end
            OP_LD, OP_ST: state_d = S_MEM;
            OP_JCC: begin
              if (take_s) pc_d = rdata_addr_s;
              else        pc_d = pc_q + ONE_A;
              state_d = S_FETCH;
            end
`ifdef CPU_CALL_EN
            default: state_d = S_CALLW;   // only CALL reaches OPND otherwise
`else
            default: state_d = S_FETCH;
`endif
          endcase
        end else begin
          state_d = S_OPND;
        end
      end

      S_MEM: begin
        if (!req_q) begin
          req_d   = 1'b1;
          we_d    = (op_s == OP_ST);
          io_d    = 1'b0;
          addr_d  = t_q;
          wdata_d = rf_q[rs_s];
        end else if (mem_ack) begin
          req_d = 1'b0;
          if (op_s == OP_LD) rf_d[rd_s] = mem_rdata;
          else               rf_d[rd_s] = rf_q[rd_s];
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end

      S_PUSH: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b1; io_d = 1'b0; addr_d = sp_q;
          wdata_d = rf_q[rs_s];
        end else if (mem_ack) begin
          req_d   = 1'b0;
          sp_d    = sp_q - ONE_A;
          state_d = S_FETCH;
        end else begin
          state_d = S_PUSH;
        end
      end

      S_POP: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b0; io_d = 1'b0; addr_d = sp_q + ONE_A;
        end else if (mem_ack) begin
          req_d      = 1'b0;
          rf_d[rd_s] = mem_rdata;
          sp_d       = sp_q + ONE_A;
          state_d    = S_FETCH;
        end else begin
          state_d = S_POP;
        end
      end

      S_IOW: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b1; io_d = 1'b1; addr_d = port_addr_s;
          wdata_d = rf_q[rs_s];
        end else if (mem_ack) begin
          req_d   = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IOW;
        end
      end

      S_HALT: state_d = S_HALT;

`ifdef CPU_CALL_EN
      S_CALLW: begin
        // PC already points past the CALL operand: that is the return address.
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b1; io_d = 1'b0; addr_d = sp_q;
          wdata_d = DATA_W'(pc_q);
        end else if (mem_ack) begin
          req_d   = 1'b0;
          sp_d    = sp_q - ONE_A;
          pc_d    = t_q;
          state_d = S_FETCH;
        end else begin
          state_d = S_CALLW;
        end
      end

      S_RETR: begin
        if (!req_q) begin
          req_d = 1'b1; we_d = 1'b0; io_d = 1'b0; addr_d = sp_q + ONE_A;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          sp_d    = sp_q + ONE_A;
          pc_d    = rdata_addr_s;
          state_d = S_FETCH;
        end else begin
          state_d = S_RETR;
        end
      end
`endif

      default: state_d = S_FETCH;
    endcase

    halted_d = (state_d == S_HALT);
  end

  // State, register file, flags and bus output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      sp_q     <= {ADDR_W{1'b1}};
      ir_q     <= 8'h00;
      t_q      <= {ADDR_W{1'b0}};
      rf_q     <= '{default: {DATA_W{1'b0}}};
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      ir_q     <= ir_d;
      t_q      <= t_d;
      rf_q     <= rf_d;
      c_q      <= c_d;
      z_q      <= z_d;
      req_q    <= req_d;
      we_q     <= we_d;
      io_q     <= io_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_io    = io_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = halted_q;
  assign flags     = {c_q, z_q};

endmodule

// File: tb/tb_cpu_core_param.sv
module tb_cpu_core_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_req, mem_we, mem_io, mem_ack, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] flags;

  always #5 clk = ~clk;

  cpu_core_param #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h10)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .halted(halted), .flags(flags)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic       we;
    logic       io;
    logic [7:0] wdata;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  int         n_checks = 0;
  int         n_err    = 0;
  bit         mon_en = 1'b0, allow_extra = 1'b0, rnd_wait = 1'b0;
  int         fixed_wait = 0;
  logic [7:0] last_rd_addr, io_addr_seen, io_data_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void exp_push(input logic [7:0] a, input logic we, input logic io,
                                   input logic [7:0] wd);
    exp_q.push_back('{a, we, io, wd});
  endfunction

  // Instruction-level reference: executes whole instructions on ref_mem and
  // records the bus transactions each one must produce, in order.
  task automatic ref_run(input int max_instr, output bit h, output logic [1:0] fl);
    logic [7:0] pc, sp, ir, t;
    logic [7:0] r [4];
    logic [3:0] op;
    logic [1:0] rd, rs;
    int         a, b, res;
    bit         c, z, take;
    pc = 8'h10; sp = 8'hFF; r = '{default: 8'h00}; c = 1'b0; z = 1'b0; h = 1'b0;
    for (int n = 0; n < max_instr && !h; n++) begin
      exp_push(pc, 1'b0, 1'b0, 8'h00);
      ir = ref_mem[pc]; pc = pc + 8'd1;
      op = ir[7:4]; rd = ir[3:2]; rs = ir[1:0];
      a = int'(r[rd]); b = int'(r[rs]);
      case (op)
        4'h0: begin
`ifdef CPU_CALL_EN
          if (rd == 2'd1) begin
            exp_push(pc, 1'b0, 1'b0, 8'h00); t = ref_mem[pc]; pc = pc + 8'd1;
            exp_push(sp, 1'b1, 1'b0, pc); ref_mem[sp] = pc; sp = sp - 8'd1; pc = t;
          end else if (rd == 2'd2) begin
            sp = sp + 8'd1; exp_push(sp, 1'b0, 1'b0, 8'h00); pc = ref_mem[sp];
          end
`endif
        end
        4'h1: begin exp_push(pc, 1'b0, 1'b0, 8'h00); r[rd] = ref_mem[pc]; pc = pc + 8'd1; end
        4'h2: begin
          exp_push(pc, 1'b0, 1'b0, 8'h00); t = ref_mem[pc]; pc = pc + 8'd1;
          exp_push(t, 1'b0, 1'b0, 8'h00); r[rd] = ref_mem[t];
        end
        4'h3: begin
          exp_push(pc, 1'b0, 1'b0, 8'h00); t = ref_mem[pc]; pc = pc + 8'd1;
          exp_push(t, 1'b1, 1'b0, r[rs]); ref_mem[t] = r[rs];
        end
        4'h4: r[rd] = r[rs];
        4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
          case (op)
            4'h5:       begin res = a + b; c = (res > 255); end
            4'h6, 4'hA: begin res = a - b; c = (a < b); end
            4'h7:       begin res = a & b; c = 1'b0; end
            4'h8:       begin res = a | b; c = 1'b0; end
            default:    begin res = a ^ b; c = 1'b0; end
          endcase
          res = res & 255;
          z = (res == 0);
          if (op != 4'hA) r[rd] = res[7:0];
        end
        4'hB: begin
          exp_push(pc, 1'b0, 1'b0, 8'h00); t = ref_mem[pc]; pc = pc + 8'd1;
          take = (rs == 2'd0) ? 1'b1 : (rs == 2'd1) ? z : (rs == 2'd2) ? !z : c;
          if (take) pc = t;
        end
        4'hC: begin exp_push(sp, 1'b1, 1'b0, r[rs]); ref_mem[sp] = r[rs]; sp = sp - 8'd1; end
        4'hD: begin sp = sp + 8'd1; exp_push(sp, 1'b0, 1'b0, 8'h00); r[rd] = ref_mem[sp]; end
        4'hE: exp_push({6'd0, rd}, 1'b1, 1'b1, r[rs]);
        default: h = 1'b1;
      endcase
    end
    fl = {c, z};
  endtask

  // Memory / I-O responder with configurable wait states.
  bit         have = 1'b0;
  int         wcnt = 0, need = 0;
  logic [17:0] lat;
  initial begin mem_ack = 1'b0; mem_rdata = 8'h00; end
  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ack = 1'b0; have = 1'b0; wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0; have = 1'b0;
    end else begin
      if (!have) begin
        have = 1'b1;
        lat  = {mem_addr, mem_we, mem_io, mem_wdata};
        need = rnd_wait ? int'($urandom_range(0, 3)) : fixed_wait;
        wcnt = 0;
      end else begin
        chk("hold_stable", {14'd0, mem_addr, mem_we, mem_io, mem_wdata}, {14'd0, lat});
      end
      if (wcnt >= need) begin
        mem_ack = 1'b1;
        if (mem_we && mem_io) begin
          io_addr_seen = mem_addr; io_data_seen = mem_wdata;
        end else if (mem_we) begin
          mem[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr]; last_rd_addr = mem_addr;
        end
      end else begin
        wcnt++;
      end
    end
  end

  // Monitor: every completed handshake must match the next expected transaction.
  always @(negedge clk) begin
    txn_t e;
    #1;
    if (mon_en && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        if (!allow_extra) begin
          n_checks++; n_err++;
          $display("FAIL bus_extra: got unexpected access addr=%h we=%b io=%b", mem_addr, mem_we, mem_io);
        end
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (mem_addr !== e.addr || mem_we !== e.we || mem_io !== e.io ||
            (e.we && mem_wdata !== e.wdata)) begin
          n_err++;
          $display("FAIL bus_txn: got addr=%h we=%b io=%b wd=%h expected addr=%h we=%b io=%b wd=%h",
                   mem_addr, mem_we, mem_io, mem_wdata, e.addr, e.we, e.io, e.wdata);
        end
      end
    end
  end

  task automatic load_prog(input logic [7:0] base, input logic [7:0] prog[$]);
    foreach (prog[i]) mem[base + 8'(i)] = prog[i];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic run_prog(input int max_instr);
    bit         eh;
    logic [1:0] ef;
    int         cyc, reqs, mism;
    @(negedge clk); reset = 1'b1; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_flags", {30'd0, flags}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    ref_run(max_instr, eh, ef);
    allow_extra = !eh;
    mon_en = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("first_fetch", {21'd0, mem_req, mem_we, mem_io, mem_addr}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h10});
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 6000) begin @(negedge clk); #2; cyc++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL run_timeout: got %0d pending transactions expected 0", exp_q.size());
    end
    if (eh) begin
      repeat (4) @(negedge clk);
      chk("halted", {31'd0, halted}, 32'd1);
      chk("final_flags", {30'd0, flags}, {30'd0, ef});
      reqs = 0;
      repeat (20) begin @(negedge clk); if (mem_req) reqs++; end
      chk("no_req_after_hlt", reqs, 0);
    end
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);
    mon_en = 1'b0;
  endtask

  task automatic reset_mid_opnd();
    int cyc;
    clear_mem();
    load_prog(8'h10, '{8'h10, 8'h55, 8'hF0});
    rnd_wait = 1'b0; fixed_wait = 8; mon_en = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    cyc = 0;
    while (!(mem_req && mem_addr == 8'h11) && cyc < 200) begin @(negedge clk); cyc++; end
    chk("opnd_reached", {31'd0, cyc < 200}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abandon_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("restart_fetch", {21'd0, mem_req, mem_we, mem_io, mem_addr}, {21'd0, 1'b1, 1'b0, 1'b0, 8'h10});
  endtask

  initial begin
    reset = 1'b1;
    clear_mem();

    // LDI R0,#F0; LDI R1,#20; ADD R0,R1; ST [80],R0; HLT -- zero wait, then 3 waits
    for (int w = 0; w < 2; w++) begin
      clear_mem();
      load_prog(8'h10, '{8'h10, 8'hF0, 8'h14, 8'h20, 8'h51, 8'h30, 8'h80, 8'hF0});
      rnd_wait = 1'b0; fixed_wait = (w == 0) ? 0 : 3;
      run_prog(100);
      chk("add_store", {24'd0, mem[8'h80]}, 32'h10);
      chk("add_flags", {30'd0, flags}, 32'h2);
    end

    // LDI R2,#5; CMP R2,R2; Jcc 40 -- taken for Z, falls through for NZ
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      load_prog(8'h10, '{8'h18, 8'h05, 8'hAA, (k == 0) ? 8'hB1 : 8'hB2, 8'h40, 8'hF0});
      mem[8'h40] = 8'hF0;
      rnd_wait = 1'b1;
      run_prog(100);
      chk(k == 0 ? "jz_target" : "jnz_fallthru", {24'd0, last_rd_addr}, (k == 0) ? 32'h40 : 32'h15);
    end

    // LDI R1,#20; PUSH R1; POP R3; OUT 2,R3; HLT
    clear_mem();
    load_prog(8'h10, '{8'h14, 8'h20, 8'hC1, 8'hDC, 8'hEB, 8'hF0});
    rnd_wait = 1'b1;
    run_prog(100);
    chk("push_mem", {24'd0, mem[8'hFF]}, 32'h20);
    chk("out_port", {24'd0, io_addr_seen}, 32'h2);
    chk("out_data", {24'd0, io_data_seen}, 32'h20);

`ifdef CPU_CALL_EN
    // CALL 30; HLT   with RET at 30
    clear_mem();
    load_prog(8'h10, '{8'h04, 8'h30, 8'hF0});
    mem[8'h30] = 8'h08;
    rnd_wait = 1'b1;
    run_prog(100);
    chk("call_ret_addr", {24'd0, mem[8'hFF]}, 32'h12);
    chk("ret_target", {24'd0, last_rd_addr}, 32'h12);
`endif

    reset_mid_opnd();

    // Random memory images, random wait states.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      rnd_wait = 1'b1;
      run_prog(60);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
